// File: rtl/est_run_sequencer_if.sv
// est_run_sequencer_if: estimator control/result signals plus the valid/ready total output port
interface est_run_sequencer_if;
  logic        est_reset;
  logic        est_set_seed;
  logic [31:0] est_seed;
  logic        est_enable;
  logic [31:0] est_result;
  logic        est_done;
  logic [39:0] out_sum;
  logic [7:0]  out_runs;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  modport master (
    output est_reset, est_set_seed, est_seed, est_enable, out_sum, out_runs, out_err, out_valid,
    input  est_result, est_done, out_ready
  );
  modport slave (
    input  est_reset, est_set_seed, est_seed, est_enable, out_sum, out_runs, out_err, out_valid,
    output est_result, est_done, out_ready
  );
endinterface

// File: rtl/est_run_sequencer.sv
// est_run_sequencer: runs the pi estimator back-to-back with advancing seeds and sums the per-run results
module est_run_sequencer #(
  parameter logic [31:0] SEED_STEP = 32'h9E37_79B9,
  parameter int          TIMEOUT   = 1 << 24,
  parameter int          TO_W      = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         seed_in,
  input  logic [7:0]          num_runs,
  output logic                busy,
  est_run_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, SEED, RUN, CAPTURE, OUTPUT} state_t;
  state_t          r_state, w_next;
  logic [31:0]     r_seed, w_seed_add, w_seed_next;
  logic [7:0]      r_left, r_runs;
  logic [39:0]     r_sum;
  logic            r_err;
  logic [TO_W-1:0] r_to;
  logic            r_est_reset, r_est_set_seed, r_est_enable, r_out_valid, r_busy;
  logic            w_timeout;
  assign w_timeout   = r_to == TO_W'(TIMEOUT - 1);
  assign w_seed_add  = r_seed + SEED_STEP;
  assign w_seed_next = (w_seed_add == 32'd0) ? 32'd1 : w_seed_add;
  assign bus.est_reset    = r_est_reset;
  assign bus.est_set_seed = r_est_set_seed;
  assign bus.est_seed     = r_seed;
  assign bus.est_enable   = r_est_enable;
  assign bus.out_sum      = r_sum;
  assign bus.out_runs     = r_runs;
  assign bus.out_err      = r_err;
  assign bus.out_valid    = r_out_valid;
  assign busy             = r_busy;
  // Next-state decode; est_done wins over a coincident timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ((num_runs == 8'd0) ? OUTPUT : CLEAR) : IDLE;
      CLEAR:   w_next = SEED;
      SEED:    w_next = RUN;
      RUN:     w_next = bus.est_done ? CAPTURE : (w_timeout ? OUTPUT : RUN);
      CAPTURE: w_next = (r_left == 8'd1) ? OUTPUT : CLEAR;
      OUTPUT:  w_next = bus.out_ready ? IDLE : OUTPUT;
      default: w_next = IDLE;
    endcase
  end
  // State, datapath and strobes registered from the next state so they align with it glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_seed         <= '0;
      r_left         <= '0;
      r_runs         <= '0;
      r_sum          <= '0;
      r_err          <= 1'b0;
      r_to           <= '0;
      r_est_reset    <= 1'b0;
      r_est_set_seed <= 1'b0;
      r_est_enable   <= 1'b0;
      r_out_valid    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_est_reset    <= w_next == CLEAR;
      r_est_set_seed <= w_next == SEED;
      r_est_enable   <= w_next == RUN;
      r_out_valid    <= w_next == OUTPUT;
      r_busy         <= w_next != IDLE;
      case (r_state)
        IDLE: if (start) begin
          r_seed <= seed_in;
          r_left <= num_runs;
          r_sum  <= '0;
          r_runs <= '0;
          r_err  <= 1'b0;
        end
        CLEAR: r_to <= '0;
        RUN: begin
          r_to <= r_to + 1'b1;
          if (!bus.est_done && w_timeout) r_err <= 1'b1;
        end
        CAPTURE: begin
          r_sum  <= r_sum + {8'd0, bus.est_result};
          r_runs <= r_runs + 8'd1;
          r_left <= r_left - 8'd1;
          r_seed <= w_seed_next;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_est_run_sequencer.sv
// tb_est_run_sequencer: directed tests of the estimator run sequencer against hand-computed values
module tb_est_run_sequencer;
  localparam logic [31:0] STEP = 32'h9E37_79B9;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] seed_in = '0;
  logic [7:0]  num_runs = '0;
  logic        busy, busy2;
  logic        ready = 1'b1;
  int          lat = 100;
  logic        done_en = 1'b1;
  int          en_cnt = 0;
  int          nrst = 0;
  int          nbase = 0;
  logic [31:0] seeds[$];
  logic [31:0] res_tab [4];
  int          errors = 0;
  int          checks = 0;

  est_run_sequencer_if bus();
  est_run_sequencer_if bus2();

  always #5 clk = ~clk;

  est_run_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .num_runs(num_runs), .busy(busy), .bus(bus)
  );

  est_run_sequencer #(.TIMEOUT(64), .TO_W(7)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .seed_in(32'h0000_00AA),
    .num_runs(8'd3), .busy(busy2), .bus(bus2)
  );

  // Estimator model: done rises after lat enabled cycles, result picked per run
  always @(posedge clk) en_cnt <= bus.est_reset ? 0 : (bus.est_enable ? en_cnt + 1 : en_cnt);
  assign bus.est_done   = done_en && (en_cnt >= lat);
  assign bus.est_result = res_tab[2'(nrst - nbase - 1)];
  assign bus.out_ready  = ready;
  assign bus2.est_done   = 1'b0;
  assign bus2.est_result = 32'd0;
  assign bus2.out_ready  = 1'b1;

  // Strobe monitor: counts est_reset pulses and records seeds loaded
  always @(negedge clk) begin
    if (bus.est_reset) nrst <= nrst + 1;
    if (bus.est_set_seed) seeds.push_back(bus.est_seed);
  end

  task automatic start_batch(input logic [31:0] s, input logic [7:0] n);
    seed_in = s;
    num_runs = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int from, output int cyc);
    cyc = from;
    while (!bus.out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({busy, bus.est_reset, bus.est_set_seed, bus.est_enable, bus.out_valid, bus.out_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=000000", {busy, bus.est_reset, bus.est_set_seed, bus.est_enable, bus.out_valid, bus.out_err});
    end
    checks++;
    if (bus.out_sum !== 40'd0 || bus.out_runs !== 8'd0 || bus.est_seed !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got sum=%0d runs=%0d seed=%h exp 0", bus.out_sum, bus.out_runs, bus.est_seed);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int cyc;
    lat = 100;
    res_tab[0] = 32'd1000;
    nbase = nrst;
    start_batch(32'h1234_5678, 8'd1);
    checks++;
    if (bus.est_reset !== 1'b1) begin
      errors++;
      $display("FAIL single_clear_c1 got=%b exp=1", bus.est_reset);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.est_set_seed !== 1'b1 || bus.est_seed !== 32'h1234_5678) begin
      errors++;
      $display("FAIL single_seed_c2 got set=%b seed=%h exp set=1 seed=12345678", bus.est_set_seed, bus.est_seed);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.est_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_enable_c3 got=%b exp=1", bus.est_enable);
    end
    wait_valid(3, cyc);
    checks++;
    if (cyc !== 105) begin
      errors++;
      $display("FAIL single_valid_cycle got=%0d exp=105", cyc);
    end
    checks++;
    if (bus.out_sum !== 40'd1000 || bus.out_runs !== 8'd1 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL single_data got sum=%0d runs=%0d err=%b exp 1000/1/0", bus.out_sum, bus.out_runs, bus.out_err);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_multi;
    int cyc, sb;
    logic [31:0] s1, s2;
    lat = 5;
    res_tab[0] = 32'd10;
    res_tab[1] = 32'd20;
    res_tab[2] = 32'd30;
    nbase = nrst;
    sb = seeds.size();
    s1 = 32'hCAFE_0001 + STEP;
    s2 = s1 + STEP;
    start_batch(32'hCAFE_0001, 8'd3);
    wait_valid(1, cyc);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd60 || bus.out_runs !== 8'd3) begin
      errors++;
      $display("FAIL multi_data got v=%b sum=%0d runs=%0d exp 1/60/3", bus.out_valid, bus.out_sum, bus.out_runs);
    end
    checks++;
    if (nrst - nbase !== 3) begin
      errors++;
      $display("FAIL multi_reset_pulses got=%0d exp=3", nrst - nbase);
    end
    checks++;
    if (seeds.size() - sb !== 3) begin
      errors++;
      $display("FAIL multi_seed_count got=%0d exp=3", seeds.size() - sb);
    end else if (seeds[sb] !== 32'hCAFE_0001 || seeds[sb+1] !== s1 || seeds[sb+2] !== s2) begin
      errors++;
      $display("FAIL multi_seeds got %h %h %h exp cafe0001 %h %h", seeds[sb], seeds[sb+1], seeds[sb+2], s1, s2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_seed_wrap;
    int cyc, sb;
    lat = 3;
    nbase = nrst;
    sb = seeds.size();
    start_batch(32'h61C8_8647, 8'd2);
    wait_valid(1, cyc);
    checks++;
    if (seeds.size() - sb !== 2) begin
      errors++;
      $display("FAIL wrap_seed_count got=%0d exp=2", seeds.size() - sb);
    end else if (seeds[sb] !== 32'h61C8_8647 || seeds[sb+1] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL wrap_seeds got %h %h exp 61c88647 00000001", seeds[sb], seeds[sb+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int cyc;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1;
    while (!bus2.out_valid && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 67) begin
      errors++;
      $display("FAIL timeout_cycle got=%0d exp=67", cyc);
    end
    checks++;
    if (bus2.out_err !== 1'b1 || bus2.out_runs !== 8'd0 || bus2.out_sum !== 40'd0 || bus2.est_enable !== 1'b0) begin
      errors++;
      $display("FAIL timeout_data got err=%b runs=%0d sum=%0d en=%b exp 1/0/0/0", bus2.out_err, bus2.out_runs, bus2.out_sum, bus2.est_enable);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    lat = 4;
    res_tab[0] = 32'd77;
    nbase = nrst;
    ready = 1'b0;
    start_batch(32'h0000_0042, 8'd1);
    wait_valid(1, cyc);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      num_runs = 8'd0;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd77 || bus.out_runs !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b sum=%0d runs=%0d exp 1/77/1", i, bus.out_valid, bus.out_sum, bus.out_runs);
      end
    end
    start = 1'b0;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_start_ignored got busy=%b v=%b exp 0/0", busy, bus.out_valid);
    end
    start_batch(32'h0000_0099, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd0 || bus.out_runs !== 8'd0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_runs got v=%b sum=%0d runs=%0d err=%b exp 1/0/0/0", bus.out_valid, bus.out_sum, bus.out_runs, bus.out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    num_runs = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%b exp=0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got v=%b exp=1", bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    done_en = 1'b0;
    start_batch(32'h0000_0005, 8'd2);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.est_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrun_enable got=%b exp=1", bus.est_enable);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.est_enable !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async got en=%b busy=%b v=%b exp 0/0/0", bus.est_enable, busy, bus.out_valid);
    end
    @(negedge clk) reset = 1'b1;
    done_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.est_reset !== 1'b0 || bus.est_enable !== 1'b0) begin
      errors++;
      $display("FAIL midrun_stay_idle got busy=%b rst=%b en=%b exp 0/0/0", busy, bus.est_reset, bus.est_enable);
    end
  endtask

  initial begin
    res_tab[0] = '0;
    res_tab[1] = '0;
    res_tab[2] = '0;
    res_tab[3] = '0;
    test_reset;
    test_single;
    test_multi;
    test_seed_wrap;
    test_timeout;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/est_run_sequencer.md
# est_run_sequencer

Host-side sequencer for the pi estimator's `set_seed`/`enable`/`result`/`done` interface. It runs the estimator back-to-back for a programmed number of runs, advancing the seed before each run, and sums the per-run `result` values into a wide total. The total is presented on a valid/ready output port. The block sits between the PS/register logic and the estimator core.

## Interface
- `SEED_STEP`, default 32'h9E37_79B9: value added to the seed between runs (mod 2^32).
- `TIMEOUT`, default 2^24: maximum cycles allowed in RUN before a run is abandoned.
- `TO_W`, default 25: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: begins a batch; sampled only in IDLE.
- `seed_in` in 32: seed for the first run; latched on accepted `start`.
- `num_runs` in 8: run count; latched on accepted `start`.
- `est_reset` out 1: active-high clear to the estimator.
- `est_set_seed` out 1: seed load strobe to the estimator.
- `est_seed` out 32: seed value for the estimator.
- `est_enable` out 1: run enable to the estimator.
- `est_result` in 32: per-run hit count from the estimator.
- `est_done` in 1: estimator run complete (level).
- `out_sum` out 40: sum of the `est_result` values.
- `out_runs` out 8: number of runs completed.
- `out_err` out 1: set when the batch ended on timeout.
- `out_valid` out 1: output handshake valid.
- `out_ready` in 1: output handshake ready.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, SEED, RUN, CAPTURE, OUTPUT.
- IDLE:
  - On `start`=1, latch `seed_in` into `seed_q` and `num_runs` into `left_q`.
  - Clear `sum_q`, `runs_q` and `err_q`.
  - Go to CLEAR, or go directly to OUTPUT when `num_runs`=0 (sum=0, runs=0).
- CLEAR: `est_reset`=1 for exactly one cycle; clear the timeout counter; go to SEED.
- SEED: `est_set_seed`=1 for one cycle with `est_seed`=`seed_q`; go to RUN.
- RUN:
  - `est_enable`=1; the timeout counter increments every cycle.
  - On `est_done`=1, go to CAPTURE.
  - Otherwise, when the counter reaches TIMEOUT-1, set `err_q` and go to OUTPUT; partial results are discarded.
  - `est_done` has priority over timeout in the same cycle.
- CAPTURE (`est_enable`=0):
  - `sum_q` += zero-extended `est_result` (40-bit; cannot overflow for ≤255 runs).
  - `runs_q`++, `left_q`--.
  - `seed_q` ← `seed_q`+SEED_STEP; if the new value is 0, substitute 32'h0000_0001 (prevents LFSR lock-up).
  - Go to OUTPUT if `left_q` was 1, else go to CLEAR.
- OUTPUT:
  - `out_valid`=1; `out_sum`/`out_runs`/`out_err` driven from the registers and held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `est_seed` always drives `seed_q`; it is meaningful only while `est_set_seed`=1.
- `start` outside IDLE is ignored; it is not queued.
- Reset values: all outputs 0, state IDLE, `seed_q`=0.
- Asserting `reset` at any time forces IDLE in the same instant. In-flight results are lost, and `est_enable` drops immediately.

## Timing
- All strobes (`est_reset`, `est_set_seed`, `out_valid`) are registered state decodes, glitch-free.
- Batch start: `start` sampled at edge 0; CLEAR at cycle 1, SEED at cycle 2, `est_enable` high from cycle 3.
- Run completion: `est_done` sampled at edge k → CAPTURE at cycle k+1. The next run's CLEAR, or OUTPUT, follows at cycle k+2.
- Per-run overhead outside RUN is 3 cycles (CLEAR, SEED, CAPTURE).
- Output: `out_valid` asserts on the cycle OUTPUT is entered. It stays high until a handshake. `busy` deasserts the cycle after the handshake.
- Back-to-back batches: `start` held high through the handshake cycle is accepted on the first IDLE cycle.

## Test plan
- Single run: `seed_in`=32'h1234_5678, `num_runs`=1; estimator model asserts `done` 100 cycles after enable with result=1000.
  - Required: `est_set_seed` at cycle 2 with seed 32'h1234_5678.
  - Required: `out_valid` at cycle 105, `out_sum`=1000, `out_runs`=1, `out_err`=0.
- Three runs with results 10, 20, 30.
  - Required: seeds S, S+SEED_STEP, S+2·SEED_STEP.
  - Required: `out_sum`=60, `out_runs`=3, exactly three `est_reset` pulses.
- Seed wrap: `seed_in`=32'h61C8_8647, `num_runs`=2 (S+SEED_STEP=0).
  - Required: second `est_set_seed` carries 32'h0000_0001.
- Timeout: TIMEOUT=64, `est_done` never asserts.
  - Required: `out_err`=1, `out_runs`=0, `out_sum`=0.
  - Required: OUTPUT entered 64 cycles after RUN entry; `est_enable` low in OUTPUT.
- Backpressure and re-start:
  - Hold `out_ready`=0 for 20 cycles → `out_valid` and data stable throughout.
  - A `start` pulse during the stall is ignored.
  - `num_runs`=0 → immediate OUTPUT with sum 0.
- Reset mid-RUN: assert `reset` low.
  - Required: `est_enable`, `busy` and `out_valid` go 0 asynchronously.
  - Required: after release, the block stays in IDLE until the next `start`.
